// File: rtl/fir_tap_sequencer.sv
// fir_tap_sequencer
//   Read-side controller for a FIR sample shift-register stack. Accepts one
//   sample per in_valid/in_ready handshake, which pulses ld_in so the stack
//   shifts the sample in. It then sweeps adr over taps 0..N-1 and accumulates
//   tap_data*coef at full precision. The result is presented on
//   out_valid/out_ready.
//
// Ports
//   clk, rst            clock (rising edge), asynchronous active-low reset
//   in_valid, in_ready  input sample handshake (sample data goes to the stack)
//   ld_in               stack load/shift enable (in_valid & in_ready)
//   adr                 stack/coefficient tap address (0 = newest sample)
//   tap_data, coef      tap sample and its coefficient, combinational from adr
//   out_data, out_valid registered filter result and its valid
//   out_ready           downstream accepts the result
//   busy                block is sweeping or holding a result
module fir_tap_sequencer #(
    parameter int STACK_SIZE = 64,
    parameter int DATA_WIDTH = 16,
    parameter int COEF_WIDTH = 16,
    parameter int ACC_WIDTH  = DATA_WIDTH + COEF_WIDTH + $clog2(STACK_SIZE)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic                          ld_in,
    output logic [$clog2(STACK_SIZE)-1:0] adr,
    input  logic [DATA_WIDTH-1:0]         tap_data,
    input  logic [COEF_WIDTH-1:0]         coef,
    output logic [ACC_WIDTH-1:0]          out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          busy
);
    localparam int AW = $clog2(STACK_SIZE);
    localparam int PW = DATA_WIDTH + COEF_WIDTH;

    typedef enum logic [1:0] {IDLE, MAC, DONE} state_e;

    state_e                 state_q, state_d;
    logic [AW-1:0]          adr_q, adr_d;
    logic [ACC_WIDTH-1:0]   acc_q, acc_d;
    logic [ACC_WIDTH-1:0]   out_data_q, out_data_d;
    logic                   out_valid_q, out_valid_d;

    logic signed [PW-1:0]   prod;
    logic [ACC_WIDTH-1:0]   prod_ext;

    // Both operands signed so the product is a true signed full-width result.
    assign prod     = $signed(tap_data) * $signed(coef);
    assign prod_ext = {{(ACC_WIDTH-PW){prod[PW-1]}}, prod};

    always_comb begin
        state_d     = state_q;
        adr_d       = adr_q;
        acc_d       = acc_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        in_ready    = 1'b0;
        ld_in       = 1'b0;
        case (state_q)
            IDLE: begin
                // Gated by rst so nothing handshakes while reset is held.
                in_ready = rst;
                ld_in    = in_valid & in_ready;
                if (ld_in) begin
                    acc_d   = '0;
                    adr_d   = '0;
                    state_d = MAC;
                end
            end
            MAC: begin
                acc_d = acc_q + prod_ext;
                if (adr_q == AW'(STACK_SIZE-1)) begin
                    // Last tap: publish the final sum directly so out_data
                    // is valid from the first DONE cycle.
                    adr_d       = '0;
                    out_data_d  = acc_d;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end else begin
                    adr_d = adr_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                adr_d       = '0;
                out_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            adr_q       <= '0;
            acc_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            adr_q       <= adr_d;
            acc_q       <= acc_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign adr       = adr_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_fir_tap_sequencer.sv
module tb_fir_tap_sequencer;
    localparam int N    = 8;
    localparam int DW   = 16;
    localparam int CW   = 16;
    localparam int AW   = 3;
    localparam int ACCW = 35;

    logic clk = 1'b0, rst = 1'b0;
    logic in_valid = 1'b0, out_ready = 1'b1;
    logic in_ready, ld_in, out_valid, busy;
    logic [AW-1:0] adr;
    logic signed [DW-1:0] in_data = '0, tap_data;
    logic signed [CW-1:0] coef;
    logic signed [ACCW-1:0] out_data;

    logic signed [DW-1:0] stk [N];
    logic signed [CW-1:0] crom [N];

    int errors = 0, checks = 0;
    longint hist[$];

    typedef struct {
        logic signed [DW-1:0] din;
        longint               exp;
    } vec_t;
    vec_t tbl[$];

    always #5 clk = ~clk;

    fir_tap_sequencer #(.STACK_SIZE(N), .DATA_WIDTH(DW), .COEF_WIDTH(CW), .ACC_WIDTH(ACCW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .ld_in(ld_in),
        .adr(adr), .tap_data(tap_data), .coef(coef), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
    );

    // Sample stack and coefficient ROM surrounding the sequencer.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N; i++) stk[i] <= '0;
        end else if (ld_in) begin
            for (int i = N-1; i > 0; i--) stk[i] <= stk[i-1];
            stk[0] <= in_data;
        end
    end
    assign tap_data = stk[adr];
    assign coef     = crom[adr];

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Filter output from the list of samples accepted since reset.
    function automatic longint model_exp();
        longint s = 0;
        for (int k = 0; k < N; k++)
            if (k < hist.size()) s += hist[hist.size()-1-k] * longint'(crom[k]);
        return s;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b0;
        hist.delete();
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    // Called just after a negedge with the DUT idle. Returns just after a
    // negedge with the DUT back in IDLE.
    task automatic do_sample(input logic signed [DW-1:0] d, input longint exp_in,
                             input bit use_model, input int hold, input string nm);
        int t;
        longint exp;
        in_data  = d;
        in_valid = 1'b1;
        #1;
        t = 0;
        while (!ld_in && t < 50) begin
            @(negedge clk); #1; t++;
        end
        chk({nm, " accept"}, longint'(ld_in), 1);
        hist.push_back(longint'(d));
        exp = use_model ? model_exp() : exp_in;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        for (int c = 1; c <= N; c++) begin
            chk({nm, " adr"}, longint'(adr), longint'(c-1));
            chk({nm, " mac busy/ready/valid"}, {busy, in_ready, out_valid}, 3'b100);
            @(negedge clk); #1;
        end
        chk({nm, " out_valid"}, longint'(out_valid), 1);
        chk({nm, " out_data"}, longint'(out_data), exp);
        if (hold > 0) begin
            out_ready = 1'b0;
            in_valid  = 1'b1;
            in_data   = DW'($urandom);
            repeat (hold) begin
                @(negedge clk); #1;
                chk({nm, " hold valid/ready/ld"}, {out_valid, in_ready, ld_in}, 3'b100);
                chk({nm, " hold data"}, longint'(out_data), exp);
            end
            out_ready = 1'b1;
        end
        @(negedge clk);
        #1;
        chk({nm, " back idle"}, {out_valid, in_ready, busy}, 3'b010);
        chk({nm, " retained"}, longint'(out_data), exp);
        if (hold > 0) chk({nm, " ld after release"}, longint'(ld_in), 1);
        in_valid = 1'b0;
    endtask

    task automatic run_tbl(input string nm);
        for (int i = 0; i < tbl.size(); i++)
            do_sample(tbl[i].din, tbl[i].exp, 1'b0, 0, $sformatf("%s[%0d]", nm, i));
        tbl.delete();
    endtask

    initial begin
        int pulses[$];
        for (int k = 0; k < N; k++) crom[k] = 1;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst outputs", {out_valid, in_ready, ld_in, busy}, 4'b0000);
        chk("rst adr", longint'(adr), 0);
        chk("rst out_data", longint'(out_data), 0);
        rst = 1'b1;
        #1;
        chk("rst release ready", longint'(in_ready), 1);

        // Running sum, coef=1
        do_reset();
        for (int i = 1; i <= N; i++) tbl.push_back('{DW'(i), longint'(i*(i+1)/2)});
        run_tbl("runsum");

        // Impulse, coef[k]=k+1
        do_reset();
        for (int k = 0; k < N; k++) crom[k] = CW'(k+1);
        tbl.push_back('{16'sd1, 64'sd1});
        for (int i = 1; i < N; i++) tbl.push_back('{16'sd0, longint'(i+1)});
        tbl.push_back('{16'sd0, 64'sd0});
        run_tbl("impulse");

        // Signed extremes
        do_reset();
        for (int k = 0; k < N; k++) crom[k] = -16'sd32768;
        for (int i = 1; i <= N; i++) tbl.push_back('{-16'sd32768, longint'(i) << 30});
        run_tbl("extreme");

        // Negative mix
        do_reset();
        for (int k = 0; k < N; k++) crom[k] = '0;
        crom[0] = 16'sd5;
        tbl.push_back('{-16'sd3, -64'sd15});
        run_tbl("negmix");

        // Backpressure with in_valid high in DONE, then the pending sample is taken
        do_reset();
        for (int k = 0; k < N; k++) crom[k] = 1;
        do_sample(16'sd5, 64'sd5, 1'b0, 5, "bp");
        do_sample(16'sd7, 64'sd12, 1'b0, 0, "bp next");

        // Throughput: in_valid and out_ready held high
        do_reset();
        in_data  = '0;
        in_valid = 1'b1;
        for (int c = 0; c < 35; c++) begin
            #1;
            if (ld_in) pulses.push_back(c);
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk("tput pulses", longint'(pulses.size()), 4);
        for (int i = 1; i < pulses.size(); i++)
            chk("tput gap", longint'(pulses[i] - pulses[i-1]), N+2);
        repeat (N+3) @(negedge clk);

        // Reset mid-sweep
        do_reset();
        in_data  = 16'sd9;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        hist.delete();
        #1;
        chk("midrst outputs", {out_valid, in_ready, ld_in, busy}, 4'b0000);
        chk("midrst adr", longint'(adr), 0);
        in_valid = 1'b1;
        repeat (3) begin
            @(negedge clk); #1;
            chk("midrst hold", {out_valid, in_ready, ld_in, busy}, 4'b0000);
            chk("midrst hold adr", longint'(adr), 0);
        end
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("midrst ready", longint'(in_ready), 1);
        for (int c = 0; c < N+4; c++) begin
            @(negedge clk); #1;
            chk("midrst no result", {out_valid, busy}, 2'b00);
        end

        // Randomized against the history model
        do_reset();
        for (int k = 0; k < N; k++) crom[k] = CW'($urandom);
        for (int i = 0; i < 20; i++)
            do_sample(DW'($urandom), 0, 1'b1, int'($urandom_range(0, 3)), $sformatf("rand[%0d]", i));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/fir_tap_sequencer.md
Name: fir_tap_sequencer

Overview:
Control/datapath block that sits on the read side of the FIR sample shift-register stack. It accepts one input sample per valid/ready handshake and pulses the stack's load enable for that sample. It then sweeps the stack's tap address over every tap, multiplies each tap by the matching coefficient, and accumulates the products. It presents the full-precision filter output on a valid/ready output port.

Parameters:
STACK_SIZE, 64, number of taps N; must equal the depth of the attached stack; power of 2, at least 2.
DATA_WIDTH, 16, sample width, signed two's complement.
COEF_WIDTH, 16, coefficient width, signed two's complement.
ACC_WIDTH, DATA_WIDTH+COEF_WIDTH+$clog2(STACK_SIZE), accumulator and output width.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  reset, asynchronous, active-low.
in_valid  in  1  upstream sample valid; in_data is wired externally to the stack data input.
in_ready  out  1  sequencer can accept a sample.
ld_in  out  1  load/shift enable to the stack.
adr  out  $clog2(STACK_SIZE)  stack tap address; adr=k selects the sample loaded k handshakes before the newest (k=0 is the newest).
tap_data  in  DATA_WIDTH  stack tap output, combinational from adr.
coef  in  COEF_WIDTH  coefficient for tap adr, combinational from adr (external ROM/regfile).
out_data  out  ACC_WIDTH  filter result, signed.
out_valid  out  1  result valid.
out_ready  in  1  downstream accepts result.
busy  out  1  high when state is not IDLE.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, adr=0, acc=0, out_data=0, out_valid=0. in_ready=0 and ld_in=0 while rst is low.
- States:
  - IDLE: in_ready=1. If in_valid=1, then ld_in=1 (ld_in = in_valid & in_ready, combinational) and the stack shifts at this edge; acc<=0, adr<=0, go to MAC.
  - MAC: each cycle acc <= acc + sext(tap_data*coef), with a signed full-precision product. When adr=N-1, go to DONE; otherwise adr<=adr+1.
  - DONE: out_valid=1, out_data=acc. If out_ready=1, go to IDLE.
- adr: returns to 0 on leaving MAC; held at 0 in IDLE and DONE. No wrap beyond N-1.
- Outputs: out_valid and out_data are driven from registers only. out_data is held stable in DONE regardless of out_ready. out_data retains the last result after leaving DONE.
- Port exclusivity: in_ready=0 and ld_in=0 in MAC and DONE. in_valid is ignored outside IDLE, so the stack never shifts mid-sweep.
- Latency: input handshake in cycle 0, MAC cycles 1..N, out_valid first high in cycle N+1. Output handshake in cycle N+1 returns to IDLE in cycle N+2. Maximum throughput is one sample per N+2 cycles.
- Arithmetic: no saturation or rounding. ACC_WIDTH guarantees no overflow for any input (worst case N*2^(DATA_WIDTH+COEF_WIDTH-2)).
- Reset mid-operation (MAC or DONE): the result is discarded, no out_valid pulse is issued, and the block restarts in IDLE. Stack contents are governed by the stack's own reset on the shared rst.

Test Plan:
- Reset: assert rst=0 for 3 cycles during a MAC sweep -> out_valid=0, adr=0, in_ready=0, busy=0 during reset; in_ready=1 on the first cycle after release; no spurious result.
- Running sum (N=8, coef=1 all taps): push samples 1..8 with out_ready=1 -> outputs 1,3,6,10,15,21,28,36.
- Impulse (N=8, coef[k]=k+1): push 1 then seven 0s, then one more 0 -> outputs 1,2,3,4,5,6,7,8, then 0.
- Signed extremes (N=8, DATA/COEF=16, coef=-32768 all taps): push -32768 eight times -> k-th output = k*2^30; 8th = 2^33 in the 35-bit out_data, with no overflow. Negative mix: sample -3, coef 5 on tap 0 only -> -15.
- Backpressure: hold out_ready=0 for 5 cycles in DONE with in_valid=1 -> out_data stable, out_valid=1, in_ready=0, ld_in never asserted; release -> IDLE next cycle and the sample is accepted.
- Latency/throughput (N=8): handshake in cycle 0 -> adr 0..7 in cycles 1..8, out_valid in cycle 9. With in_valid and out_ready held high -> ld_in pulses every 10 cycles.
